gt_link_sequencer: RTL and testbench

GT_LINK_SEQUENCER -- requirements
Module: gt_link_sequencer

---
 rtl/gt_link_seq_pkg.sv | 31 +++
 rtl/gt_link_sync.sv | 24 ++
 rtl/gt_link_sequencer.sv | 168 ++++++++++++++++
 tb/tb_gt_link_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/gt_link_seq_pkg.sv
// Shared definitions for the GT link bring-up sequencer: state encoding,
// timer sizing and the output decode used by the top level.
package gt_link_seq_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_PWR  = 3'd1;
    localparam logic [2:0] ST_RESET_ALL = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd4;
    localparam logic [2:0] ST_LINK_UP   = 3'd5;
    localparam logic [2:0] ST_RX_RESET  = 3'd6;
    localparam logic [2:0] ST_FAIL      = 3'd7;

    // Timer is wide enough for the longest terminal count (value - 1).
    function automatic int timer_width(input int powerup_wait,
                                       input int lock_timeout,
                                       input int reset_pulse);
        int m;
        m = (powerup_wait > lock_timeout) ? powerup_wait : lock_timeout;
        m = (m > reset_pulse) ? m : reset_pulse;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic logic holds_full_reset(input logic [2:0] st);
        case (st)
            ST_IDLE, ST_WAIT_PWR, ST_RESET_ALL, ST_FAIL: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/gt_link_sync.sv
// Two-flop synchronizer bank for asynchronous status inputs.
module gt_link_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= {WIDTH{1'b0}};
            q      <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/gt_link_sequencer.sv
// Transceiver link bring-up sequencer: power-good qualification, full and
// RX datapath resets, lock monitoring with bounded retries.
module gt_link_sequencer
    import gt_link_seq_pkg::*;
#(
    parameter int POWERUP_WAIT = 1024,
    parameter int RESET_PULSE  = 16,
    parameter int LOCK_TIMEOUT = 125000,
    parameter int MAX_RETRIES  = 7
) (
    input  logic        clk_125mhz_int,
    input  logic        gt_tx_reset,
    input  logic        enable,
    input  logic        gtpowergood,
    input  logic        reset_tx_done,
    input  logic        reset_rx_done,
    input  logic        rx_block_lock,
    input  logic        rx_high_ber,
    output logic        gt_reset_all,
    output logic        gt_reset_rx_datapath,
    output logic        link_up,
    output logic        link_fail,
    output logic [2:0]  state,
    output logic [3:0]  retry_count,
    output logic [15:0] link_drop_count
);

    localparam int TIMER_W = timer_width(POWERUP_WAIT, LOCK_TIMEOUT, RESET_PULSE);
    localparam logic [TIMER_W-1:0] PWR_LAST   = TIMER_W'(POWERUP_WAIT - 1);
    localparam logic [TIMER_W-1:0] PULSE_LAST = TIMER_W'(RESET_PULSE - 1);
    localparam logic [TIMER_W-1:0] TO_LAST    = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]         RETRY_MAX  = 4'(MAX_RETRIES);

    logic [4:0] status_s;
    logic       powergood_s, tx_done_s, rx_done_s, block_lock_s, high_ber_s;

    logic [2:0]         state_r, state_nxt;
    logic [TIMER_W-1:0] timer_r, timer_cnt, timer_nxt;
    logic [3:0]         retry_r, retry_nxt;
    logic [15:0]        drop_r, drop_nxt;

    gt_link_sync #(.WIDTH(5)) u_sync (
        .clk (clk_125mhz_int),
        .rst (gt_tx_reset),
        .d   ({gtpowergood, reset_tx_done, reset_rx_done, rx_block_lock, rx_high_ber}),
        .q   (status_s)
    );

    assign {powergood_s, tx_done_s, rx_done_s, block_lock_s, high_ber_s} = status_s;

    // Next-state, timer, retry and drop-counter decisions.
    always_comb begin
        state_nxt = state_r;
        timer_cnt = timer_r;
        retry_nxt = retry_r;
        drop_nxt  = drop_r;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else if (!powergood_s && (state_r != ST_IDLE) && (state_r != ST_WAIT_PWR)) begin
            state_nxt = ST_WAIT_PWR;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt = ST_WAIT_PWR;
                    retry_nxt = 4'd0;
                end
                ST_WAIT_PWR: begin
                    if (!powergood_s) begin
                        timer_cnt = {TIMER_W{1'b0}};
                    end else if (timer_r == PWR_LAST) begin
                        state_nxt = ST_RESET_ALL;
                    end else begin
                        timer_cnt = timer_r + TIMER_W'(1);
                    end
                end
                ST_RESET_ALL, ST_RX_RESET: begin
                    if (timer_r == PULSE_LAST) begin
                        state_nxt = ST_WAIT_DONE;
                    end else begin
                        timer_cnt = timer_r + TIMER_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (tx_done_s && rx_done_s) begin
                        state_nxt = ST_WAIT_LOCK;
                    end else if (timer_r == TO_LAST) begin
                        if (retry_r == RETRY_MAX) begin
                            state_nxt = ST_FAIL;
                        end else begin
                            retry_nxt = retry_r + 4'd1;
                            state_nxt = ST_RESET_ALL;
                        end
                    end else begin
                        timer_cnt = timer_r + TIMER_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (block_lock_s && !high_ber_s) begin
                        state_nxt = ST_LINK_UP;
                        retry_nxt = 4'd0;
                    end else if (timer_r == TO_LAST) begin
                        if (retry_r == RETRY_MAX) begin
                            state_nxt = ST_FAIL;
                        end else begin
                            retry_nxt = retry_r + 4'd1;
                            state_nxt = ST_RX_RESET;
                        end
                    end else begin
                        timer_cnt = timer_r + TIMER_W'(1);
                    end
                end
                ST_LINK_UP: begin
                    // A lock loss recovers via the RX datapath without spending a retry.
                    if (!block_lock_s || high_ber_s) begin
                        state_nxt = ST_RX_RESET;
                        drop_nxt  = (drop_r == 16'hFFFF) ? drop_r : drop_r + 16'd1;
                    end else begin
                        state_nxt = ST_LINK_UP;
                    end
                end
                ST_FAIL: begin
                    state_nxt = ST_FAIL;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
        timer_nxt = (state_nxt != state_r) ? {TIMER_W{1'b0}} : timer_cnt;
    end

    // Sequencer state registers.
    always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
        if (gt_tx_reset) begin
            state_r <= ST_IDLE;
            timer_r <= {TIMER_W{1'b0}};
            retry_r <= 4'd0;
            drop_r  <= 16'd0;
        end else begin
            state_r <= state_nxt;
            timer_r <= timer_nxt;
            retry_r <= retry_nxt;
            drop_r  <= drop_nxt;
        end
    end

    // Registered outputs decoded from the current state, one cycle behind it.
    always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
        if (gt_tx_reset) begin
            gt_reset_all         <= 1'b1;
            gt_reset_rx_datapath <= 1'b0;
            link_up              <= 1'b0;
            link_fail            <= 1'b0;
            state                <= ST_IDLE;
            retry_count          <= 4'd0;
            link_drop_count      <= 16'd0;
        end else begin
            gt_reset_all         <= holds_full_reset(state_r);
            gt_reset_rx_datapath <= (state_r == ST_RX_RESET);
            link_up              <= (state_r == ST_LINK_UP);
            link_fail            <= (state_r == ST_FAIL);
            state                <= state_r;
            retry_count          <= retry_r;
            link_drop_count      <= drop_r;
        end
    end

endmodule

// File: tb/tb_gt_link_sequencer.sv
// Directed bench for gt_link_sequencer: a cycle-timed vector table for the
// nominal bring-up and link drop, plus hand-written timeout/glitch/reset cases.
module tb_gt_link_sequencer;

    localparam int PW = 8;
    localparam int RP = 4;
    localparam int LT = 100;
    localparam int MR = 2;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    logic rst, enable, pg, txd, rxd, lock, ber;
    logic gra, rxr, lu, lf;
    logic [2:0]  st;
    logic [3:0]  rc;
    logic [15:0] dc;

    int checks = 0;
    int failures = 0;

    gt_link_sequencer #(
        .POWERUP_WAIT (PW),
        .RESET_PULSE  (RP),
        .LOCK_TIMEOUT (LT),
        .MAX_RETRIES  (MR)
    ) dut (
        .clk_125mhz_int       (clk),
        .gt_tx_reset          (rst),
        .enable               (enable),
        .gtpowergood          (pg),
        .reset_tx_done        (txd),
        .reset_rx_done        (rxd),
        .rx_block_lock        (lock),
        .rx_high_ber          (ber),
        .gt_reset_all         (gra),
        .gt_reset_rx_datapath (rxr),
        .link_up              (lu),
        .link_fail            (lf),
        .state                (st),
        .retry_count          (rc),
        .link_drop_count      (dc)
    );

    // inputs {en,pg,txd,rxd,lock,ber}; advance adv cycles then compare all outputs
    typedef struct {
        logic [5:0]  in;
        int          adv;
        logic [26:0] exp;
    } vec_t;

    vec_t tbl[20];

    function automatic logic [26:0] ex(input logic [2:0] s, input logic g, input logic r,
                                       input logic u, input logic f, input logic [3:0] c,
                                       input logic [15:0] d);
        return {s, g, r, u, f, c, d};
    endfunction

    function automatic vec_t mk(input logic [5:0] in, input int adv, input logic [26:0] e);
        vec_t v;
        v.in  = in;
        v.adv = adv;
        v.exp = e;
        return v;
    endfunction

    function automatic logic [26:0] snap();
        return {st, gra, rxr, lu, lf, rc, dc};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_in(input logic [5:0] v);
        {enable, pg, txd, rxd, lock, ber} = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(6'b000000);
        cyc(3);
        chk("reset_state", 32'(snap()), 32'(ex(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0)));
        rst = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] v, input int budget, input string name);
        for (int i = 0; i < budget && st !== v; i++) cyc(1);
        chk(name, 32'(st), 32'(v));
    endtask

    initial begin
        int n, pulses, plen, bad_len, touts, bad;
        logic prev_rxr;
        logic [2:0] prev_st;

        // Nominal bring-up, single-cycle lock loss, then powergood loss in LINK_UP.
        tbl[0]  = mk(6'b110000,  2, ex(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0));
        tbl[1]  = mk(6'b110000,  8, ex(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0));
        tbl[2]  = mk(6'b110000,  1, ex(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0));
        tbl[3]  = mk(6'b110000,  3, ex(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0));
        tbl[4]  = mk(6'b110000,  1, ex(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0));
        tbl[5]  = mk(6'b110000, 16, ex(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0));
        tbl[6]  = mk(6'b111100,  3, ex(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0));
        tbl[7]  = mk(6'b111100,  1, ex(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0));
        tbl[8]  = mk(6'b111100, 26, ex(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0));
        tbl[9]  = mk(6'b111110,  3, ex(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0));
        tbl[10] = mk(6'b111110,  1, ex(3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'd0));
        tbl[11] = mk(6'b111100,  1, ex(3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'd0));
        tbl[12] = mk(6'b111110,  2, ex(3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'd0));
        tbl[13] = mk(6'b111110,  1, ex(3'd6, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'd1));
        tbl[14] = mk(6'b111110,  3, ex(3'd6, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'd1));
        tbl[15] = mk(6'b111110,  1, ex(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd1));
        tbl[16] = mk(6'b111110,  1, ex(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd1));
        tbl[17] = mk(6'b111110,  1, ex(3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'd1));
        tbl[18] = mk(6'b101110,  3, ex(3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'd1));
        tbl[19] = mk(6'b101110,  1, ex(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd1));

        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_in(tbl[i].in);
            cyc(tbl[i].adv);
            chk($sformatf("nominal_row%0d", i), 32'(snap()), 32'(tbl[i].exp));
        end

        // Done never arrives: WAIT_DONE lasts LT cycles then back to RESET_ALL.
        do_reset();
        set_in(6'b110000);
        wait_state(3'd3, 50, "done_reach_wait_done");
        n = 0;
        while (st === 3'd3 && n < 300) begin
            cyc(1);
            n++;
        end
        chk("done_timeout_dwell", 32'(n), 32'(LT));
        chk("done_timeout_retry", 32'({st, rc}), 32'({3'd2, 4'd1}));

        // Lock never arrives: three WAIT_LOCK timeouts, two RX pulses, then FAIL.
        do_reset();
        set_in(6'b111100);
        pulses = 0; plen = 0; bad_len = 0; touts = 0;
        prev_rxr = 1'b0;
        prev_st = st;
        for (int i = 0; i < 1500 && lf !== 1'b1; i++) begin
            cyc(1);
            if (rxr === 1'b1) plen++;
            else if (prev_rxr === 1'b1) begin
                pulses++;
                if (plen != RP) bad_len++;
                plen = 0;
            end
            if (prev_st == 3'd4 && (st == 3'd6 || st == 3'd7)) touts++;
            prev_rxr = rxr;
            prev_st = st;
        end
        chk("lock_fail_reached", 32'(lf), 32'(1));
        chk("lock_rx_pulses", 32'(pulses), 32'(2));
        chk("lock_rx_pulse_len_errs", 32'(bad_len), 32'(0));
        chk("lock_timeouts", 32'(touts), 32'(3));
        chk("lock_fail_state", 32'({st, rc, gra}), 32'({3'd7, 4'd2, 1'b1}));
        cyc(5);
        chk("fail_terminal", 32'({st, lf}), 32'({3'd7, 1'b1}));
        enable = 1'b0;
        cyc(1);
        chk("fail_exit_pending", 32'({st, lf}), 32'({3'd7, 1'b1}));
        cyc(1);
        chk("fail_exit_idle", 32'({st, lf, gra}), 32'({3'd0, 1'b0, 1'b1}));

        // Powergood glitch during WAIT_PWR restarts the qualification count.
        do_reset();
        set_in(6'b110000);
        cyc(6);
        pg = 1'b0;
        cyc(1);
        pg = 1'b1;
        cyc(4);
        chk("glitch_hold_t11", 32'(st), 32'(1));
        cyc(6);
        chk("glitch_hold_t17", 32'(st), 32'(1));
        cyc(1);
        chk("glitch_reset_all_t18", 32'(st), 32'(2));

        // Async reset asserted in the middle of an RX datapath pulse.
        do_reset();
        set_in(6'b111110);
        wait_state(3'd5, 60, "rst_reach_link_up");
        lock = 1'b0;
        cyc(1);
        lock = 1'b1;
        for (int i = 0; i < 20 && rxr !== 1'b1; i++) cyc(1);
        chk("rst_rx_pulse_seen", 32'({rxr, dc}), 32'({1'b1, 16'd1}));
        cyc(1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", 32'(snap()), 32'(ex(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0)));
        #1;
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (rxr !== 1'b0 || gra !== 1'b1) bad++;
        end
        chk("rst_no_partial_pulse", 32'(bad), 32'(0));
        chk("rst_restart_wait_pwr", 32'(st), 32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
